// File: rtl/bpfcap_job_sched.sv
// ---------------------------------------------------------------------------
// bpfcap_job_sched
//
// Purpose:
//   Accepts capture jobs (pkt_begin, pkt_end, write_address, id) from the host
//   into a small FIFO. Each job is programmed into the bpfcap engine's CSR
//   slave over Avalon-MM, one at a time. For each job the scheduler writes the
//   three address CSRs and sets GO. It then polls the control register until
//   DONE is seen or the poll budget runs out, and reports a completion.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   job_valid/job_ready        host push handshake (ready = FIFO not full)
//   job_begin/end/waddr/id     job payload
//   avm_*                      Avalon-MM master towards the engine CSRs
//                              (0 ctrl, 1 begin, 2 end, 3 waddr)
//   cpl_valid/cpl_id/cpl_status  one-cycle completion report
//                              (status 0 OK, 1 REJECT, 2 TIMEOUT)
//   fifo_level                 queued jobs, not counting the active one
//   busy                       scheduler is working on a job
// ---------------------------------------------------------------------------
module bpfcap_job_sched #(
    parameter int DEPTH    = 4,
    parameter int POLL_GAP = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [31:0]              job_begin,
    input  logic [31:0]              job_end,
    input  logic [31:0]              job_waddr,
    input  logic [3:0]               job_id,
    output logic [2:0]               avm_address,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    output logic                     avm_read,
    input  logic [31:0]              avm_readdata,
    input  logic                     avm_waitrequest,
    output logic                     cpl_valid,
    output logic [3:0]               cpl_id,
    output logic [1:0]               cpl_status,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_REJECT  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // ABORT issues the control write of 0 that cancels a timed-out capture.
    typedef enum logic [3:0] {
        IDLE, CHECK, WR_BEG, WR_END, WR_ADDR, WR_GO,
        POLL_RD, POLL_WAIT, GAP, ABORT, CPL
    } state_t;

    state_t state_q, state_d;

    logic [99:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push, pop;

    logic [31:0] act_beg_q, act_end_q, act_waddr_q;
    logic [3:0]  act_id_q;
    logic [1:0]  status_q, status_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic to_hit;
    logic rd_done;
    logic unused_rd;

    // Only DONE (bit1) of the control register matters to the scheduler.
    assign rd_done   = avm_readdata[1];
    assign unused_rd = ^{avm_readdata[31:2], avm_readdata[0]};

    // Ready is based on the occupancy before any pop in the same cycle.
    assign job_ready  = (level_q != LVL_FULL);
    assign push       = job_valid && job_ready;
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE);
    assign to_hit     = (to_q == TO_MAX);

    // Job storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {job_id, job_waddr, job_end, job_begin};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // The active job is latched at pop time so the FIFO head can keep moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_beg_q   <= '0;
            act_end_q   <= '0;
            act_waddr_q <= '0;
            act_id_q    <= '0;
        end else if (pop) begin
            {act_id_q, act_waddr_q, act_end_q, act_beg_q} <= fifo_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= ST_OK;
            to_q     <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            to_q     <= to_d;
            gap_q    <= gap_d;
        end
    end

    // Bus outputs depend only on state and the active job, so they hold
    // steady for the whole time the slave stalls a transfer.
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        to_d          = to_q;
        gap_d         = gap_q;
        pop           = 1'b0;
        avm_address   = 3'd0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        avm_read      = 1'b0;
        cpl_valid     = 1'b0;
        cpl_id        = 4'd0;
        cpl_status    = 2'd0;

        // The poll budget runs through every polling state and sticks at the limit.
        if ((state_q == POLL_RD) || (state_q == POLL_WAIT) || (state_q == GAP)) begin
            to_d = to_hit ? to_q : to_q + TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (act_end_q <= act_beg_q) begin
                    status_d = ST_REJECT;
                    state_d  = CPL;
                end else begin
                    state_d = WR_BEG;
                end
            end
            WR_BEG: begin
                avm_write     = 1'b1;
                avm_address   = 3'd1;
                avm_writedata = act_beg_q;
                if (!avm_waitrequest) begin
                    state_d = WR_END;
                end
            end
            WR_END: begin
                avm_write     = 1'b1;
                avm_address   = 3'd2;
                avm_writedata = act_end_q;
                if (!avm_waitrequest) begin
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: begin
                avm_write     = 1'b1;
                avm_address   = 3'd3;
                avm_writedata = act_waddr_q;
                if (!avm_waitrequest) begin
                    state_d = WR_GO;
                end
            end
            WR_GO: begin
                avm_write     = 1'b1;
                avm_address   = 3'd0;
                avm_writedata = 32'h1;
                if (!avm_waitrequest) begin
                    to_d    = '0;
                    state_d = POLL_RD;
                end
            end
            POLL_RD: begin
                // A read in flight is always finished, even past the limit.
                avm_read    = 1'b1;
                avm_address = 3'd0;
                if (!avm_waitrequest) begin
                    state_d = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                // DONE wins over a timeout reached in the same cycle.
                if (rd_done) begin
                    status_d = ST_OK;
                    state_d  = CPL;
                end else if (to_hit) begin
                    state_d = ABORT;
                end else begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (to_hit) begin
                    state_d = ABORT;
                end else if (gap_q == GAP_LAST) begin
                    state_d = POLL_RD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ABORT: begin
                avm_write     = 1'b1;
                avm_address   = 3'd0;
                avm_writedata = 32'h0;
                if (!avm_waitrequest) begin
                    status_d = ST_TIMEOUT;
                    state_d  = CPL;
                end
            end
            CPL: begin
                cpl_valid  = 1'b1;
                cpl_id     = act_id_q;
                cpl_status = status_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bpfcap_job_sched.sv
// ---------------------------------------------------------------------------
// tb_bpfcap_job_sched
//
// Purpose:
//   Drives bpfcap_job_sched with directed and randomised jobs. The bench
//   contains a behavioural CSR slave whose stall length and DONE timing can
//   be set. Expected CSR writes and completions are derived from each job's
//   values and compared with what the slave actually observes.
// ---------------------------------------------------------------------------
module tb_bpfcap_job_sched;

    localparam int DEPTH    = 4;
    localparam int POLL_GAP = 8;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_begin = '0;
    logic [31:0] job_end = '0;
    logic [31:0] job_waddr = '0;
    logic [3:0]  job_id = '0;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        cpl_valid;
    logic [3:0]  cpl_id;
    logic [1:0]  cpl_status;
    logic [2:0]  fifo_level;
    logic        busy;

    bpfcap_job_sched #(
        .DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_begin(job_begin), .job_end(job_end), .job_waddr(job_waddr), .job_id(job_id),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_status(cpl_status),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration: stall cycles per transfer and the poll number
    // (counted from GO) on which DONE first reads back; 0 means never.
    int wait_n = 0;
    int done_after = 1;

    int  cyc = 0;
    int  stall = 0;
    int  reads_since_go = 0;
    int  rd_total = 0;
    int  pop_cyc = 0;
    int  cpl_cyc = 0;
    int  last_cpl_cyc = -1000;
    bit  rd_pending = 0;
    bit  done_now = 0;
    bit  held = 0;
    bit  prev_cpl = 0;
    logic [2:0]  h_addr;
    logic        h_wr, h_rd;
    logic [31:0] h_data;

    logic [34:0] wr_log[$];
    logic [34:0] exp_wr[$];
    logic [5:0]  cpl_log[$];
    logic [5:0]  exp_cpl[$];
    int          rd_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural CSR slave plus bus monitor, evaluated mid-cycle so that
    // DUT outputs are settled and waitrequest/readdata are ready by the edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            avm_waitrequest = 1'b0;
            stall      = 0;
            held       = 0;
            rd_pending = 0;
            prev_cpl   = 0;
        end else begin
            if (rd_pending) begin
                avm_readdata = ($urandom & ~32'h2) | (done_now ? 32'h2 : 32'h0);
            end else begin
                avm_readdata = $urandom;
            end
            rd_pending = 0;

            if (held) begin
                chk("hold_addr", avm_address, h_addr);
                chk("hold_wr", avm_write, h_wr);
                chk("hold_rd", avm_read, h_rd);
                chk("hold_data", avm_writedata, h_data);
            end
            if (avm_read && avm_write) begin
                chk("rd_wr_both", 1, 0);
            end

            if (avm_read || avm_write) begin
                if (stall < wait_n) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                    held   = 1;
                    h_addr = avm_address;
                    h_wr   = avm_write;
                    h_rd   = avm_read;
                    h_data = avm_writedata;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall = 0;
                    held  = 0;
                    if (avm_write) begin
                        wr_log.push_back({avm_address, avm_writedata});
                        if (avm_address == 3'd0 && avm_writedata == 32'h1) reads_since_go = 0;
                        if (avm_address == 3'd1) chk("csr_gap", (cyc - last_cpl_cyc) >= 2, 1);
                    end else begin
                        reads_since_go++;
                        rd_total++;
                        rd_cyc.push_back(cyc);
                        rd_pending = 1;
                        done_now   = (done_after > 0) && (reads_since_go >= done_after);
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall = 0;
                held  = 0;
            end

            if (cpl_valid) begin
                if (prev_cpl) chk("cpl_pulse", 1, 0);
                cpl_log.push_back({cpl_id, cpl_status});
                cpl_cyc      = cyc;
                last_cpl_cyc = cyc;
            end
            prev_cpl = cpl_valid;
            if (!busy && fifo_level != 3'd0) pop_cyc = cyc;
        end
    end

    // Reference model: what a job must produce, straight from its values.
    task automatic push_job(input logic [31:0] b, input logic [31:0] e,
                            input logic [31:0] w, input logic [3:0] id);
        int n = 0;
        job_begin = b;
        job_end   = e;
        job_waddr = w;
        job_id    = id;
        job_valid = 1'b1;
        while (!job_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!job_ready) chk("push_wait", 0, 1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        if (e <= b) begin
            exp_cpl.push_back({id, 2'd1});
        end else begin
            exp_wr.push_back({3'd1, b});
            exp_wr.push_back({3'd2, e});
            exp_wr.push_back({3'd3, w});
            exp_wr.push_back({3'd0, 32'h1});
            if (done_after == 0) begin
                exp_wr.push_back({3'd0, 32'h0});
                exp_cpl.push_back({id, 2'd2});
            end else begin
                exp_cpl.push_back({id, 2'd0});
            end
        end
    endtask

    task automatic wait_cpl(input int n, input int bound);
        int c = 0;
        while (cpl_log.size() < n && c < bound) begin
            @(posedge clk);
            c++;
        end
        chk("cpl_wait", cpl_log.size() >= n, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
        chk({tag, "_ncpl"}, cpl_log.size(), exp_cpl.size());
        for (int i = 0; i < exp_cpl.size() && i < cpl_log.size(); i++)
            chk({tag, "_cpl"}, cpl_log[i], exp_cpl[i]);
        wr_log.delete();
        exp_wr.delete();
        cpl_log.delete();
        exp_cpl.delete();
        rd_cyc.delete();
        rd_total = 0;
    endtask

    initial begin
        logic [31:0] b, e;
        int n;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_cpl", {cpl_valid, cpl_id, cpl_status}, 0);
        chk("rst_bus", {avm_write, avm_read, avm_address, avm_writedata}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: ideal single job.
        wait_n = 0;
        done_after = 1;
        push_job(32'h0, 32'h800, 32'h8000, 4'd3);
        wait_cpl(1, 200);
        chk("t1_latency", cpl_cyc - pop_cyc, 8);
        chk("t1_reads", rd_total, 1);
        check_logs("t1");

        // 2: fill the queue while the engine needs several polls.
        done_after = 3;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_job($urandom_range(0, 1000), 32'h1000 + $urandom_range(0, 1000),
                     $urandom, 4'(i + 5));
            chk("t2_level", fifo_level, (i == 0) ? 1 : i);
        end
        chk("t2_ready_low", job_ready, 0);
        chk("t2_level_full", fifo_level, DEPTH);
        wait_cpl(DEPTH + 1, 3000);
        chk("t2_level_empty", fifo_level, 0);
        check_logs("t2");

        // 3: rejected job, then a normal one.
        done_after = 1;
        push_job(32'h800, 32'h800, 32'h1234, 4'd9);
        push_job(32'h100, 32'h200, 32'h4000, 4'd10);
        wait_cpl(2, 300);
        chk("t3_reads", rd_total, 1);
        check_logs("t3");

        // 4: every transfer stalled for three cycles.
        wait_n = 3;
        push_job(32'h40, 32'h90, 32'hABCD0000, 4'd1);
        push_job($urandom_range(0, 99), 32'h7000, $urandom, 4'd2);
        wait_cpl(2, 500);
        chk("t4_reads", rd_total, 2);
        check_logs("t4");

        // 5: DONE never appears.
        wait_n = 0;
        done_after = 0;
        push_job(32'h10, 32'h20, 32'h30, 4'd7);
        wait_cpl(1, 1000);
        chk("t5_some_polls", rd_cyc.size() >= 2, 1);
        for (int i = 1; i < rd_cyc.size(); i++)
            chk("t5_poll_space", rd_cyc[i] - rd_cyc[i-1], POLL_GAP + 2);
        check_logs("t5");

        // 6: reset while programming END with two jobs waiting.
        wait_n = 3;
        done_after = 3;
        push_job(32'h1, 32'h2, 32'h3, 4'd11);
        push_job(32'h4, 32'h5, 32'h6, 4'd12);
        push_job(32'h7, 32'h8, 32'h9, 4'd13);
        n = 0;
        @(negedge clk);
        while (!(avm_write && avm_address == 3'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_wr_end", avm_write && avm_address == 3'd2, 1);
        chk("t6_queued", fifo_level, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_strobes", {avm_write, avm_read}, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", job_ready, 1);
        reset = 1'b0;
        wr_log.delete();
        exp_wr.delete();
        exp_cpl.delete();
        cpl_log.delete();
        repeat (60) @(posedge clk);
        #1;
        chk("t6_no_cpl", cpl_log.size(), 0);
        chk("t6_idle", {busy, fifo_level}, 0);
        check_logs("t6");

        // 7: randomised jobs, some rejected.
        wait_n = $urandom_range(0, 2);
        done_after = $urandom_range(1, 2);
        for (int i = 0; i < 6; i++) begin
            b = $urandom;
            if ($urandom_range(0, 3) == 0) e = b - $urandom_range(0, 16);
            else e = b + $urandom_range(1, 1000);
            push_job(b, e, $urandom, 4'($urandom_range(0, 15)));
        end
        wait_cpl(6, 3000);
        check_logs("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
